elastic_fifo_stage: RTL and testbench
=====================================

Name: elastic_fifo_stage

Overview:
- Multi-entry elastic buffer that uses the req/ack protocol of the dataflow graph on both sides.
- Placed on long routed edges in place of a chain of single "reg" operators, between a producing operator (or "in" node) and its consumer (operator, "out" node or bench consumer).
- Decouples producer/consumer stalls by up to DEPTH tokens while preserving token order and values.

Parameters:
- data_width, 32, token width in bits
- DEPTH, 4, number of storage entries; power of two, >= 2
- LEVEL_W, $clog2(DEPTH)+1, occupancy counter width (derived; do not override)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- req_l  out  1  request to upstream producer for one token
- ack_l  in  1  upstream ack pulse; din valid in the same cycle
- din  in  data_width  upstream token
- req_r  in  1  downstream consumer requests a token
- ack_r  out  1  one-cycle ack pulse to downstream; dout valid while high
- dout  out  data_width  head token, registered
- level  out  LEVEL_W  current number of stored tokens

Behaviour:
- Reset (rst_n low, asynchronous): req_l=0, ack_r=0, dout=0, level=0; read/write pointers=0. Storage contents are don't-care. Deassertion is synchronised internally with a 2-flop release (only on the release path). Reset mid-transfer drops all tokens; any ack_l seen while in reset is ignored.
- Upstream FSM (states IDLE, REQ):
  - IDLE -> REQ when level_next < DEPTH; req_l=1 in REQ.
  - REQ with ack_l=1: write din at wptr, wptr++, go to IDLE, so req_l=0 for at least one cycle (no double-ack from producer).
  - REQ and ack_l=0: hold REQ.
  - ack_l while in IDLE is ignored (protocol violation; flagged by a sim-only assertion).
- Downstream side:
  - When level>0, req_r=1 and ack_r=0: on the next edge ack_r=1, dout=mem[rptr], rptr++.
  - ack_r is always a single-cycle pulse; a new ack needs ack_r low in the previous cycle, so max rate is 1 token per 2 cycles per side (matches the operator protocol).
  - dout holds its value until the next pop.
- Latency: a token written on edge t can be acked downstream at edge t+1 at the earliest (ack_r high in cycle t+1..t+2).
- Occupancy: level increments on write, decrements on pop. Simultaneous write and pop leaves level unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally at DEPTH.
- Full (level==DEPTH): req_l is never asserted, so overflow is impossible by construction. A pop in the same cycle permits REQ on the next edge.
- Empty (level==0): ack_r stays 0 regardless of req_r. A write in cycle t permits ack_r at t+1, never in the same cycle.
- Data is passed unmodified; no arithmetic on the token.

Optional Feature:
- Macro: ELASTIC_FIFO_STATS_EN.
- Defined: adds output ports max_level (LEVEL_W, high-watermark of level) and stall_cycles (32 bits, counts cycles with req_r=1 and level==0; saturates at 2^32-1). Both reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package elastic_pkg:
  - upstream FSM state enum (IDLE, REQ)
  - function clog2_level(DEPTH)
  - localparam STALL_CNT_W=32
- Natural sub-module: elastic_fifo_mem, a DEPTH x data_width register array with one write port and one registered read port, no reset on storage. Pointers, FSM and level stay in the top module.

Test Plan:
- Reset then producer with fail_rate 0 and consumer with fail_rate 0, DEPTH=4, tokens 0..9 -> consumer receives 0..9 in order; level never exceeds 2; ack_r pulses every 2 cycles.
- Consumer req_r held 0 for 20 cycles -> level reaches 4, req_l stays 0 after the 4th ack_l; release req_r -> tokens 0,1,2,3 delivered, then streaming resumes with 4.
- Empty with req_r=1 for 10 cycles, then one token 0xDEADBEEF -> ack_r rises exactly one edge after the write, dout=0xDEADBEEF; with ELASTIC_FIFO_STATS_EN, stall_cycles=10.
- Wrap-around: 37 tokens through DEPTH=4 with random 30% stalls on both sides -> output sequence matches input exactly, no duplicates or drops.
- Assert rst_n low asynchronously mid-stream with level=3 -> req_l, ack_r, level and dout go to 0 immediately without waiting for a clock edge; after release the first token delivered is the next producer value, not stale data.
- With ELASTIC_FIFO_STATS_EN, fill to 4 then drain -> max_level=4 and stays 4 after drain.

Source files
------------

// File: rtl/elastic_pkg.sv
// Shared types and helpers for the elastic FIFO stage.
//   up_state_e   : upstream handshake FSM state (IDLE, REQ)
//   clog2_level  : occupancy counter width for a given depth
//   STALL_CNT_W  : width of the optional stall-cycle counter
package elastic_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } up_state_e;

  localparam int unsigned STALL_CNT_W = 32;

  // Counter must hold 0..depth inclusive, hence the extra bit.
  function automatic int unsigned clog2_level(input int unsigned depth);
    return 32'($clog2(depth)) + 32'd1;
  endfunction

endpackage

// File: rtl/elastic_fifo_mem.sv
// DEPTH x DATA_W register array, one write port, one registered read port.
// Storage has no reset; only the read data register is reset.
//   i_clk, i_rst_n           : clock, async active-low reset (read register only)
//   i_wr_en/i_wr_addr/i_wr_data : write port
//   i_rd_en/i_rd_addr        : read strobe and address
//   o_rd_data                : registered read data, held between reads
module elastic_fifo_mem #(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [PTR_W-1:0]  i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [PTR_W-1:0]  i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Storage write
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Registered read, holds value until the next read
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/elastic_fifo_stage.sv
// Multi-entry elastic buffer with req/ack handshakes on both sides.
// Optional statistics ports enabled by macro ELASTIC_FIFO_STATS_EN.
//   clk, rst_n   : clock, async active-low reset (release synchronised)
//   req_l, ack_l, din   : upstream request / ack pulse / token
//   req_r, ack_r, dout  : downstream request / ack pulse / head token
//   level        : number of stored tokens
//   max_level, stall_cycles : (stats build only) high-watermark, empty-stall count
module elastic_fifo_stage
  import elastic_pkg::*;
#(
  parameter  int unsigned data_width = 32,
  parameter  int unsigned DEPTH      = 4,
  localparam int unsigned LEVEL_W    = clog2_level(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  req_l,
  input  logic                  ack_l,
  input  logic [data_width-1:0] din,
  input  logic                  req_r,
  output logic                  ack_r,
  output logic [data_width-1:0] dout,
  output logic [LEVEL_W-1:0]    level
`ifdef ELASTIC_FIFO_STATS_EN
  ,
  output logic [LEVEL_W-1:0]     max_level,
  output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [1:0]         r_rst_sync;
  logic               w_rst_n;
  up_state_e          r_state;
  up_state_e          w_state_next;
  logic               w_wr_en;
  logic               w_pop;
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [LEVEL_W-1:0] r_level;
  logic [LEVEL_W-1:0] w_level_next;
  logic               r_ack_r;

  // Reset asserts immediately, releases after two clock edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Pop only on a fresh request; ack_r low in between enforces single-cycle pulses
  assign w_pop        = (r_level != '0) && req_r && !r_ack_r;
  assign w_level_next = r_level + LEVEL_W'(w_wr_en) - LEVEL_W'(w_pop);

  // Upstream FSM: state register
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Upstream FSM: next state; request again only if a slot will be free
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_level_next < LEVEL_W'(DEPTH)) w_state_next = ST_REQ;
      ST_REQ:  if (ack_l)                          w_state_next = ST_IDLE;
      default:                                     w_state_next = ST_IDLE;
    endcase
  end

  // Upstream FSM: outputs; ack_l outside REQ is ignored
  always_comb begin
    req_l   = 1'b0;
    w_wr_en = 1'b0;
    if (r_state == ST_REQ) begin
      req_l   = 1'b1;
      w_wr_en = ack_l;
    end
  end

  // Pointers, occupancy and downstream ack
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ack_r <= 1'b0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)   r_rptr <= r_rptr + PTR_W'(1);
      r_level <= w_level_next;
      r_ack_r <= w_pop;
    end
  end

  elastic_fifo_mem #(
    .DATA_W (data_width),
    .DEPTH  (DEPTH)
  ) u_mem (
    .i_clk     (clk),
    .i_rst_n   (w_rst_n),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wptr),
    .i_wr_data (din),
    .i_rd_en   (w_pop),
    .i_rd_addr (r_rptr),
    .o_rd_data (dout)
  );

  assign ack_r = r_ack_r;
  assign level = r_level;

`ifdef ELASTIC_FIFO_STATS_EN
  logic [LEVEL_W-1:0]     r_max_level;
  logic [STALL_CNT_W-1:0] r_stall_cycles;

  // High-watermark tracks the level the register is about to hold
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_max_level    <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (w_level_next > r_max_level) r_max_level <= w_level_next;
      if (req_r && (r_level == '0) && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
    end
  end

  assign max_level    = r_max_level;
  assign stall_cycles = r_stall_cycles;
`endif

`ifndef SYNTHESIS
  // Producer must not ack while no request is outstanding
  a_no_ack_in_idle: assert property (@(posedge clk) disable iff (!w_rst_n)
    !(ack_l && (r_state == ST_IDLE)));
`endif

endmodule

// File: tb/tb_elastic_fifo_stage.sv
// Scoreboard bench for elastic_fifo_stage (DEPTH=4, 32-bit tokens).
// Stats checks are compiled when ELASTIC_FIFO_STATS_EN is defined.
module tb_elastic_fifo_stage;

  logic        clk;
  logic        rst_n;
  logic        req_l;
  logic        ack_l;
  logic [31:0] din;
  logic        req_r;
  logic        ack_r;
  logic [31:0] dout;
  logic [2:0]  level;
`ifdef ELASTIC_FIFO_STATS_EN
  logic [2:0]  max_level;
  logic [31:0] stall_cycles;
`endif

  elastic_fifo_stage #(.data_width(32), .DEPTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_l  (req_l),
    .ack_l  (ack_l),
    .din    (din),
    .req_r  (req_r),
    .ack_r  (ack_r),
    .dout   (dout),
    .level  (level)
`ifdef ELASTIC_FIFO_STATS_EN
    ,
    .max_level    (max_level),
    .stall_cycles (stall_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  int          cyc = 0;

  // Producer controls
  int          prod_left  = 0;
  int          prod_stall = 0;
  logic [31:0] prod_tok   = 0;
  int          writes     = 0;
  // Consumer controls
  bit          cons_force = 1;
  int          cons_stall = 0;
  // Monitor state
  int          rx_count  = 0;
  bit          rate_chk  = 0;
  bit          have_last = 0;
  int          last_cyc  = 0;
  bit          prev_ack  = 0;
  int          max_lvl   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Producer: acks a pending request, pushes the expected token
  initial begin
    ack_l = 1'b0;
    din   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && req_l && prod_left > 0 && int'($urandom_range(99)) >= prod_stall) begin
        ack_l = 1'b1;
        din   = prod_tok;
        exp_q.push_back(prod_tok);
        prod_tok  = prod_tok + 1;
        prod_left = prod_left - 1;
        writes    = writes + 1;
      end else begin
        ack_l = 1'b0;
      end
    end
  end

  // Consumer: random requests unless the main sequence drives req_r directly
  initial begin
    req_r = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!cons_force) req_r = (int'($urandom_range(99)) >= cons_stall);
    end
  end

  // Monitor: compares each delivered token against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ack_r) begin
          chk("ack_single_pulse", 32'(prev_ack), 32'd0);
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_token: got 0x%08h expected none", dout);
          end else begin
            chk("token", dout, exp_q.pop_front());
          end
          rx_count++;
          if (rate_chk && have_last) chk("ack_interval", 32'(cyc - last_cyc), 32'd2);
          last_cyc  = cyc;
          have_last = 1;
        end
        if (int'(level) > max_lvl) max_lvl = int'(level);
        prev_ack = ack_r;
      end else begin
        prev_ack = 0;
      end
    end
  end

  task automatic do_reset();
    cons_force = 1;
    req_r      = 1'b0;
    prod_left  = 0;
    rst_n      = 1'b0;
    #1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("rst_req_l", 32'(req_l), 32'd0);
    chk("rst_ack_r", 32'(ack_r), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_dout", dout, 32'd0);
    rx_count  = 0;
    writes    = 0;
    have_last = 0;
    max_lvl   = 0;
    rst_n     = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_count < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("rx_count", 32'(rx_count), 32'(n));
  endtask

  task automatic wait_level(input int n, input int budget);
    int k = 0;
    while (int'(level) != n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("level_reached", 32'(level), 32'(n));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;

    // Full-rate streaming of tokens 0..9
    do_reset();
    cons_force = 0; cons_stall = 0; prod_stall = 0;
    rate_chk = 1;
    prod_tok = 32'd0; prod_left = 10;
    wait_rx(10, 200);
    rate_chk = 0;
    chk("stream_max_level_le2", 32'(max_lvl <= 2), 32'd1);
    chk("stream_queue_empty", 32'(exp_q.size()), 32'd0);

    // Consumer stalled: fill to DEPTH, then drain and resume
    do_reset();
    prod_stall = 0;
    prod_tok = 32'd0; prod_left = 6;
    repeat (20) @(negedge clk);
    chk("full_level", 32'(level), 32'd4);
    chk("full_req_l", 32'(req_l), 32'd0);
    chk("full_writes", 32'(writes), 32'd4);
    cons_force = 0; cons_stall = 0;
    wait_rx(6, 200);
    repeat (3) @(negedge clk);
    chk("drained_level", 32'(level), 32'd0);
`ifdef ELASTIC_FIFO_STATS_EN
    chk("max_level_after_drain", 32'(max_level), 32'd4);
`endif

    // Empty with req_r high, then one token: latency and stall count
    do_reset();
    req_r = 1'b1;
    repeat (8) @(negedge clk);
    prod_tok = 32'hDEADBEEF; prod_left = 1;
    @(negedge clk);
    chk("empty_no_ack", 32'(ack_r), 32'd0);
    @(negedge clk);
    chk("write_edge_no_ack", 32'(ack_r), 32'd0);
    chk("write_edge_level", 32'(level), 32'd1);
    @(negedge clk);
    chk("next_edge_ack", 32'(ack_r), 32'd1);
    chk("next_edge_dout", dout, 32'hDEADBEEF);
    req_r = 1'b0;
    @(negedge clk);
    chk("dout_held", dout, 32'hDEADBEEF);
`ifdef ELASTIC_FIFO_STATS_EN
    chk("stall_cycles", stall_cycles, 32'd10);
`endif

    // Wrap-around with random stalls on both sides
    do_reset();
    cons_force = 0; cons_stall = 30; prod_stall = 30;
    prod_tok = 32'd1000; prod_left = 37;
    wait_rx(37, 3000);
    @(negedge clk);
    chk("wrap_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("wrap_writes", 32'(writes), 32'd37);

    // Asynchronous reset mid-stream with level 3
    do_reset();
    prod_stall = 0;
    prod_tok = 32'h100; prod_left = 4;
    wait_level(4, 100);
    req_r = 1'b1;
    @(negedge clk);
    req_r = 1'b0;
    chk("pre_rst_level", 32'(level), 32'd3);
    chk("pre_rst_ack_r", 32'(ack_r), 32'd1);
    chk("pre_rst_req_l", 32'(req_l), 32'd1);
    chk("pre_rst_dout", dout, 32'h100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req_l", 32'(req_l), 32'd0);
    chk("async_rst_ack_r", 32'(ack_r), 32'd0);
    chk("async_rst_level", 32'(level), 32'd0);
    chk("async_rst_dout", dout, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rx_count = 0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    cons_force = 0; cons_stall = 0;
    prod_tok = 32'h200; prod_left = 3;
    wait_rx(3, 200);
    chk("post_rst_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
